vga_frame_sink: RTL and testbench
=================================

Name: vga_frame_sink

Overview:
- Receiving end of the pixel-plot interface driven by the circle/line drawing blocks: (vga_x, vga_y, vga_colour, vga_plot).
- Captures every plotted pixel into an internal 160x120x3 framebuffer.
- Clears the buffer to a selectable colour.
- Streams the whole frame back out in raster order over a valid/ready port, for the VGA scan-out and for self-checking testbenches.

Parameters:
- WIDTH, 160, pixels per line
- HEIGHT, 120, lines per frame
- CW, 3, colour bits per pixel

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- vga_x  in  8  plot column
- vga_y  in  7  plot row
- vga_colour  in  CW  plot colour
- vga_plot  in  1  write strobe, one pixel per cycle when high; no backpressure
- clear  in  1  clear request pulse, sampled in IDLE only
- clear_colour  in  CW  fill colour, latched when the clear is accepted
- busy  out  1  high in CLEAR or READ
- rd_start  in  1  frame readout request pulse, sampled in IDLE only
- rd_valid  out  1  readout pixel valid
- rd_ready  in  1  consumer accepts pixel
- rd_x  out  8  column of current readout pixel
- rd_y  out  7  row of current readout pixel
- rd_colour  out  CW  colour of current readout pixel
- rd_last  out  1  high with pixel (WIDTH-1, HEIGHT-1)
- drop_count  out  16  count of rejected plots, saturating

Behaviour:
- Memory: WIDTH*HEIGHT entries of CW bits, address = y*160 + x, computed as (y<<7)+(y<<5)+x, 15 bits. Synchronous write; synchronous read with 1-cycle latency.
- Reset values (asserted asynchronously):
  - state = CLEAR, fill colour = 0, clear counter = 0
  - busy = 1, rd_valid = 0, rd_last = 0
  - rd_x = 0, rd_y = 0, rd_colour = 0, drop_count = 0
  - Power-up therefore always zero-fills the frame.
- States: CLEAR, IDLE, READ.
- CLEAR:
  - Writes the fill colour to one address per cycle, 0 to 19199.
  - Moves to IDLE on the cycle after address 19199 is written. Total 19200 cycles, busy = 1 throughout.
  - Plots arriving in CLEAR are discarded and counted as drops.
  - clear and rd_start are ignored.
- IDLE:
  - busy = 0.
  - clear=1 latches clear_colour and enters CLEAR next cycle.
  - rd_start=1 enters READ.
  - If both are asserted, clear wins.
- Plot acceptance, in IDLE and READ:
  - vga_plot=1 with x<160 and y<120 writes vga_colour at that address the same edge.
  - x>=160 or y>=120 is discarded and counted as a drop.
  - Repeated writes to the same address: last write wins.
- READ:
  - Raster order: x increments 0..159, then y increments; starts at (0,0).
  - The first rd_valid rises 2 cycles after rd_start is sampled (address issue + memory latency).
  - rd_valid, rd_x, rd_y, rd_colour and rd_last are held stable while rd_valid=1 and rd_ready=0.
  - Handshake completes on rd_valid & rd_ready. The next pixel is presented with at most 1 bubble cycle; a prefetch register permits full throughput, 1 pixel/cycle.
  - After the handshake of the rd_last pixel: rd_valid = 0 and return to IDLE the next cycle.
  - A plot to an address not yet read appears in the stream. A plot to the address being fetched in the same cycle returns the old data.
- drop_count: increments by 1 per rejected plot; saturates at 16'hFFFF.
- Reset mid-CLEAR or mid-READ aborts the operation immediately and restarts the zero-fill.

Optional Feature:
- DROP_CNT_EN defined: drop_count is implemented as described above.
- Not defined: drop_count is tied to 16'd0, no counter flops are built, and rejected plots are still discarded silently.

Test Plan:
- Release rstn, hold rd_ready=1, pulse rd_start once busy=0 -> busy high for exactly 19200 cycles after reset; the stream has 19200 pixels, all colour 0, and rd_last=1 only at (159,119).
- In IDLE, plot (0,0)=3'b101, (159,119)=3'b010, (80,60)=3'b111, then read the frame -> those three pixels return the plotted values; every other pixel returns 0.
- Pulse clear with clear_colour=3'b011 while vga_plot=1 every cycle to (10,10) -> the read frame is all 3'b011 and drop_count = 19200 (DROP_CNT_EN defined).
- Plot x=160, then y=120, then x=255 -> no memory change and drop_count=3; with DROP_CNT_EN undefined, drop_count stays 0.
- During READ, toggle rd_ready randomly -> no pixel is lost or duplicated, outputs stay stable while stalled, and rd_last appears once.
- Assert rstn=0 midway through a READ -> rd_valid=0 and busy=1 immediately, then a full zero-fill of 19200 cycles follows.

Source files
------------

// File: rtl/vga_frame_sink_if.sv
// rtl/vga_frame_sink_if.sv - pixel-plot, control and raster readout bundle for vga_frame_sink
interface vga_frame_sink_if #(
  parameter int CW = 3
);
  logic [7:0]    vga_x;
  logic [6:0]    vga_y;
  logic [CW-1:0] vga_colour;
  logic          vga_plot;
  logic          clear;
  logic [CW-1:0] clear_colour;
  logic          busy;
  logic          rd_start;
  logic          rd_valid;
  logic          rd_ready;
  logic [7:0]    rd_x;
  logic [6:0]    rd_y;
  logic [CW-1:0] rd_colour;
  logic          rd_last;
  logic [15:0]   drop_count;

  modport master (
    output vga_x, vga_y, vga_colour, vga_plot, clear, clear_colour, rd_start, rd_ready,
    input  busy, rd_valid, rd_x, rd_y, rd_colour, rd_last, drop_count
  );

  modport slave (
    input  vga_x, vga_y, vga_colour, vga_plot, clear, clear_colour, rd_start, rd_ready,
    output busy, rd_valid, rd_x, rd_y, rd_colour, rd_last, drop_count
  );
endinterface

// File: rtl/vga_frame_sink.sv
// rtl/vga_frame_sink.sv - plot-capture framebuffer with clear and raster readout; DROP_CNT_EN builds the drop counter
module vga_frame_sink #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int CW     = 3
) (
  input  logic            clk,
  input  logic            rstn,
  vga_frame_sink_if.slave sif
);
  localparam int          NPIX      = WIDTH * HEIGHT;
  localparam logic [14:0] LAST_ADDR = 15'(NPIX - 1);
  localparam logic [7:0]  X_MAX     = 8'(WIDTH - 1);
  localparam logic [6:0]  Y_MAX     = 7'(HEIGHT - 1);

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;

  // y*160 + x built from shifts so no multiplier is needed
  function automatic logic [14:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
    return {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
  endfunction

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] fill_q, fill_d;
  logic [14:0]   clr_addr_q, clr_addr_d;

  // read issue pointer
  logic [7:0]    iss_x_q, iss_x_d;
  logic [6:0]    iss_y_q, iss_y_d;
  logic          iss_done_q, iss_done_d;

  // coordinates travelling alongside the in-flight memory read
  logic          mem_vld_q, mem_vld_d;
  logic [7:0]    mem_x_q, mem_x_d;
  logic [6:0]    mem_y_q, mem_y_d;
  logic          mem_last_q, mem_last_d;

  // prefetch (skid) register, filled only while the output is stalled
  logic          sk_vld_q, sk_vld_d;
  logic [7:0]    sk_x_q, sk_x_d;
  logic [6:0]    sk_y_q, sk_y_d;
  logic [CW-1:0] sk_col_q, sk_col_d;
  logic          sk_last_q, sk_last_d;

  // presented pixel
  logic          out_vld_q, out_vld_d;
  logic [7:0]    out_x_q, out_x_d;
  logic [6:0]    out_y_q, out_y_d;
  logic [CW-1:0] out_col_q, out_col_d;
  logic          out_last_q, out_last_d;

  logic [CW-1:0] mem [NPIX];
  logic [CW-1:0] mem_rdata;
  logic          mem_we;
  logic [14:0]   mem_waddr;
  logic [CW-1:0] mem_wdata;

  logic          in_range;
  logic          plot_ok;
  logic [14:0]   plot_addr;
  logic [14:0]   iss_addr;
  logic          pop;
  logic          issue;
  logic [1:0]    slots;

  assign in_range  = (sif.vga_x <= X_MAX) && (sif.vga_y <= Y_MAX);
  assign plot_ok   = sif.vga_plot && in_range && (state_q != S_CLEAR);
  assign plot_addr = pix_addr(sif.vga_x, sif.vga_y);
  assign iss_addr  = pix_addr(iss_x_q, iss_y_q);
  assign pop       = out_vld_q && sif.rd_ready;
  // pixels already committed to the pipeline; never exceeds two
  assign slots     = {1'b0, out_vld_q} + {1'b0, sk_vld_q} + {1'b0, mem_vld_q};

  assign sif.busy      = (state_q != S_IDLE);
  assign sif.rd_valid  = out_vld_q;
  assign sif.rd_x      = out_x_q;
  assign sif.rd_y      = out_y_q;
  assign sif.rd_colour = out_col_q;
  assign sif.rd_last   = out_last_q;

  // single write port: clear fill owns it in CLEAR, accepted plots otherwise
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = plot_addr;
    mem_wdata = sif.vga_colour;
    if (state_q == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr_q;
      mem_wdata = fill_q;
    end else if (plot_ok) begin
      mem_we = 1'b1;
    end
  end

  // framebuffer storage; read-before-write so a same-cycle plot returns old data
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (issue) mem_rdata <= mem[iss_addr];
  end

  // state machine, read issue and output pipeline next-state
  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    clr_addr_d = clr_addr_q;
    iss_x_d    = iss_x_q;
    iss_y_d    = iss_y_q;
    iss_done_d = iss_done_q;
    mem_vld_d  = 1'b0;
    mem_x_d    = mem_x_q;
    mem_y_d    = mem_y_q;
    mem_last_d = mem_last_q;
    sk_vld_d   = sk_vld_q;
    sk_x_d     = sk_x_q;
    sk_y_d     = sk_y_q;
    sk_col_d   = sk_col_q;
    sk_last_d  = sk_last_q;
    out_vld_d  = out_vld_q;
    out_x_d    = out_x_q;
    out_y_d    = out_y_q;
    out_col_d  = out_col_q;
    out_last_d = out_last_q;
    issue      = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_addr_d = clr_addr_q + 15'd1;
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = S_IDLE;
          clr_addr_d = 15'd0;
        end
      end
      S_IDLE: begin
        if (sif.clear) begin
          state_d    = S_CLEAR;
          fill_d     = sif.clear_colour;
          clr_addr_d = 15'd0;
        end else if (sif.rd_start) begin
          state_d    = S_READ;
          iss_x_d    = 8'd0;
          iss_y_d    = 7'd0;
          iss_done_d = 1'b0;
        end
      end
      S_READ: begin
        issue = !iss_done_q && ((slots < 2'd2) || pop);
        if (issue) begin
          mem_vld_d  = 1'b1;
          mem_x_d    = iss_x_q;
          mem_y_d    = iss_y_q;
          mem_last_d = (iss_x_q == X_MAX) && (iss_y_q == Y_MAX);
          if (iss_x_q == X_MAX) begin
            iss_x_d = 8'd0;
            if (iss_y_q == Y_MAX) iss_done_d = 1'b1;
            else iss_y_d = iss_y_q + 7'd1;
          end else begin
            iss_x_d = iss_x_q + 8'd1;
          end
        end
        if (pop || !out_vld_q) begin
          if (sk_vld_q) begin
            out_vld_d  = 1'b1;
            out_x_d    = sk_x_q;
            out_y_d    = sk_y_q;
            out_col_d  = sk_col_q;
            out_last_d = sk_last_q;
            sk_vld_d   = mem_vld_q;
            if (mem_vld_q) begin
              sk_x_d    = mem_x_q;
              sk_y_d    = mem_y_q;
              sk_col_d  = mem_rdata;
              sk_last_d = mem_last_q;
            end
          end else if (mem_vld_q) begin
            out_vld_d  = 1'b1;
            out_x_d    = mem_x_q;
            out_y_d    = mem_y_q;
            out_col_d  = mem_rdata;
            out_last_d = mem_last_q;
          end else begin
            out_vld_d = 1'b0;
          end
        end else if (mem_vld_q) begin
          sk_vld_d  = 1'b1;
          sk_x_d    = mem_x_q;
          sk_y_d    = mem_y_q;
          sk_col_d  = mem_rdata;
          sk_last_d = mem_last_q;
        end
        if (pop && out_last_q) state_d = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // control registers; reset aborts any operation and restarts the zero-fill
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_CLEAR;
      fill_q     <= '0;
      clr_addr_q <= 15'd0;
      iss_x_q    <= 8'd0;
      iss_y_q    <= 7'd0;
      iss_done_q <= 1'b0;
      mem_vld_q  <= 1'b0;
      mem_x_q    <= 8'd0;
      mem_y_q    <= 7'd0;
      mem_last_q <= 1'b0;
      sk_vld_q   <= 1'b0;
      sk_x_q     <= 8'd0;
      sk_y_q     <= 7'd0;
      sk_col_q   <= '0;
      sk_last_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      out_x_q    <= 8'd0;
      out_y_q    <= 7'd0;
      out_col_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      clr_addr_q <= clr_addr_d;
      iss_x_q    <= iss_x_d;
      iss_y_q    <= iss_y_d;
      iss_done_q <= iss_done_d;
      mem_vld_q  <= mem_vld_d;
      mem_x_q    <= mem_x_d;
      mem_y_q    <= mem_y_d;
      mem_last_q <= mem_last_d;
      sk_vld_q   <= sk_vld_d;
      sk_x_q     <= sk_x_d;
      sk_y_q     <= sk_y_d;
      sk_col_q   <= sk_col_d;
      sk_last_q  <= sk_last_d;
      out_vld_q  <= out_vld_d;
      out_x_q    <= out_x_d;
      out_y_q    <= out_y_d;
      out_col_q  <= out_col_d;
      out_last_q <= out_last_d;
    end
  end

`ifdef DROP_CNT_EN
  logic        plot_drop;
  logic [15:0] drop_q, drop_d;

  assign plot_drop      = sif.vga_plot && !plot_ok;
  assign sif.drop_count = drop_q;

  // saturating count of plots that were rejected
  always_comb begin
    drop_d = drop_q;
    if (plot_drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  // drop counter register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) drop_q <= 16'd0;
    else       drop_q <= drop_d;
  end
`else
  assign sif.drop_count = 16'd0;
`endif
endmodule

// File: tb/tb_vga_frame_sink.sv
// tb/tb_vga_frame_sink.sv - randomized self-checking bench for vga_frame_sink against a frame-array model
module tb_vga_frame_sink;
  localparam int W    = 160;
  localparam int H    = 120;
  localparam int NPIX = W * H;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  // free-running clock
  always #5 clk = ~clk;

  vga_frame_sink_if #(.CW(3)) bus ();

  vga_frame_sink #(.WIDTH(W), .HEIGHT(H), .CW(3)) dut (
    .clk  (clk),
    .rstn (rstn),
    .sif  (bus)
  );

  logic [2:0] frame [NPIX];
  int         exp_drops;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] exp_drop_count();
`ifdef DROP_CNT_EN
    return (exp_drops > 65535) ? 16'hFFFF : 16'(exp_drops);
`else
    return 16'd0;
`endif
  endfunction

  task automatic model_fill(input logic [2:0] c);
    for (int i = 0; i < NPIX; i++) frame[i] = c;
  endtask

  // one plot cycle; model decides acceptance from the visible busy flag
  task automatic plot(input int x, input int y, input logic [2:0] c);
    bus.vga_x      = 8'(x);
    bus.vga_y      = 7'(y);
    bus.vga_colour = c;
    bus.vga_plot   = 1'b1;
    if (bus.busy || x >= W || y >= H) exp_drops++;
    else frame[y * W + x] = c;
    @(negedge clk);
    bus.vga_plot = 1'b0;
  endtask

  task automatic wait_fill(input string tag);
    int cnt;
    cnt = 0;
    while (bus.busy && cnt < 30000) begin
      cnt++;
      @(negedge clk);
    end
    check_eq(tag, cnt, NPIX);
  endtask

  // consume up to stop_at pixels with rd_ready high pct% of the time
  task automatic read_frame(input int pct, input int stop_at);
    int lat, idx, guard, run, max_run;
    bit stalled;
    logic [19:0] now_v, held, want;
    bus.rd_ready = 1'b0;
    bus.rd_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rd_start = 1'b0;
    lat = 0;
    while (!bus.rd_valid && lat < 10) begin
      lat++;
      @(negedge clk);
    end
    check_eq("rd_latency", lat, 2);
    idx = 0; guard = 0; run = 0; max_run = 0; stalled = 1'b0; held = '0;
    while (idx < stop_at && guard < 4 * NPIX) begin
      now_v = {bus.rd_valid, bus.rd_last, bus.rd_x, bus.rd_y, bus.rd_colour};
      if (stalled) check_eq("stall_hold", now_v, held);
      if (bus.rd_valid) begin
        run = 0;
        bus.rd_ready = ($urandom_range(99) < pct);
        if (bus.rd_ready) begin
          want = {1'b1, (idx == NPIX - 1), 8'(idx % W), 7'(idx / W), frame[idx]};
          check_eq("pixel", now_v, want);
          idx++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = now_v;
        end
      end else begin
        run++;
        if (run > max_run) max_run = run;
        bus.rd_ready = 1'($urandom_range(1));
        stalled = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    check_eq("rd_count", idx, stop_at);
    check_eq("bubble_run_le1", (max_run <= 1), 1);
    if (stop_at == NPIX) begin
      check_eq("end_valid", bus.rd_valid, 0);
      check_eq("end_idle", bus.busy, 0);
    end
  endtask

  // clear request (with a competing rd_start) while plotting into the clear
  task automatic clear_with_plots(input logic [2:0] c);
    int cnt;
    bus.clear        = 1'b1;
    bus.clear_colour = c;
    bus.rd_start     = 1'b1;
    @(negedge clk);
    model_fill(c);
    bus.clear    = 1'b0;
    bus.rd_start = 1'b0;
    cnt = 0;
    while (bus.busy && cnt < 30000) begin
      bus.vga_x      = 8'd10;
      bus.vga_y      = 7'd10;
      bus.vga_colour = 3'($urandom_range(7));
      bus.vga_plot   = 1'b1;
      exp_drops++;
      cnt++;
      @(negedge clk);
    end
    bus.vga_plot = 1'b0;
    check_eq("clear_busy", cnt, NPIX);
  endtask

  // test sequence
  initial begin
    bus.vga_x = '0; bus.vga_y = '0; bus.vga_colour = '0; bus.vga_plot = 1'b0;
    bus.clear = 1'b0; bus.clear_colour = '0; bus.rd_start = 1'b0; bus.rd_ready = 1'b0;
    exp_drops = 0;
    model_fill(3'd0);

    repeat (3) @(negedge clk);
    check_eq("rst_busy", bus.busy, 1);
    check_eq("rst_valid", bus.rd_valid, 0);
    check_eq("rst_last", bus.rd_last, 0);
    check_eq("rst_x", bus.rd_x, 0);
    check_eq("rst_y", bus.rd_y, 0);
    check_eq("rst_colour", bus.rd_colour, 0);
    check_eq("rst_drops", bus.drop_count, 0);
    rstn = 1'b1;
    wait_fill("por_fill");

    for (int i = 0; i < 40; i++)
      plot($urandom_range(255), $urandom_range(127), 3'($urandom_range(7)));
    plot(160, 5, 3'd6);
    plot(5, 120, 3'd6);
    plot(255, 119, 3'd6);
    plot(80, 60, 3'd1);
    plot(0, 0, 3'b101);
    plot(159, 119, 3'b010);
    plot(80, 60, 3'b111);
    check_eq("drops_plots", bus.drop_count, exp_drop_count());
    check_eq("model_corner", frame[NPIX - 1], 3'b010);
    read_frame(80, NPIX);

    clear_with_plots(3'b011);
    check_eq("drops_clear", bus.drop_count, exp_drop_count());
    read_frame(100, 4000);

    rstn = 1'b0;
    bus.rd_ready = 1'b0;
    #1;
    check_eq("abort_valid", bus.rd_valid, 0);
    check_eq("abort_busy", bus.busy, 1);
    @(negedge clk);
    rstn = 1'b1;
    exp_drops = 0;
    model_fill(3'd0);
    wait_fill("abort_fill");
    check_eq("abort_drops", bus.drop_count, exp_drop_count());
    check_eq("abort_idle_valid", bus.rd_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
